// File: rtl/demux4way16_router.sv
// demux4way16_router: steers a 16-bit word stream into four per-channel FIFOs.
// Latency: one cycle, so a word accepted at edge N is visible on its channel after edge N.
// Backpressure: in_ready is low only when the addressed channel is full. Each channel drains under its own valid/ready.
// Optional stall counter: define DEMUX4WAY16_ROUTER_STATS_EN to add stat_drops/stat_clr.
module demux4way16_router #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out0_data,
  output logic [15:0] out1_data,
  output logic [15:0] out2_data,
  output logic [15:0] out3_data,
  output logic        out0_valid,
  output logic        out1_valid,
  output logic        out2_valid,
  output logic        out3_valid,
`ifdef DEMUX4WAY16_ROUTER_STATS_EN
  output logic [7:0]  stat_drops,
  input  logic        stat_clr,
`endif
  input  logic        out0_ready,
  input  logic        out1_ready,
  input  logic        out2_ready,
  input  logic        out3_ready
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Per-channel storage and bookkeeping
  logic [15:0]      r_mem [4][DEPTH];
  logic [PTR_W-1:0] r_wp  [4];
  logic [PTR_W-1:0] r_rp  [4];
  logic [PTR_W:0]   r_cnt [4];

  logic [3:0]  w_full;
  logic [3:0]  w_empty;
  logic [3:0]  w_out_rdy;
  logic [3:0]  w_pop;
  logic [3:0]  w_push_ch;
  logic [15:0] w_head [4];
  logic        w_in_ready;
  logic        w_push;

  assign w_out_rdy = {out3_ready, out2_ready, out1_ready, out0_ready};

  // Only the addressed channel gates acceptance; a pop in the same cycle does not free a full channel
  assign w_in_ready = ~w_full[in_sel];
  assign w_push     = in_valid & w_in_ready;
  assign in_ready   = w_in_ready;

  // Status, pop/push decode and head-word selection per channel
  always_comb begin
    w_full    = '0;
    w_empty   = '0;
    w_pop     = '0;
    w_push_ch = '0;
    for (int k = 0; k < 4; k++) begin
      w_full[k]    = (r_cnt[k] == FULL_CNT);
      w_empty[k]   = (r_cnt[k] == '0);
      w_pop[k]     = w_out_rdy[k] & ~w_empty[k];
      w_push_ch[k] = w_push & (in_sel == 2'(k));
      // Empty channels present zero so a drained slot never leaks stale data
      w_head[k]    = w_empty[k] ? 16'h0000 : r_mem[k][r_rp[k]];
    end
  end

  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign out2_data  = w_head[2];
  assign out3_data  = w_head[3];
  assign out0_valid = ~w_empty[0];
  assign out1_valid = ~w_empty[1];
  assign out2_valid = ~w_empty[2];
  assign out3_valid = ~w_empty[3];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_wp[k]  <= '0;
        r_rp[k]  <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push_ch[k]) r_wp[k] <= r_wp[k] + 1'b1;
        if (w_pop[k])     r_rp[k] <= r_rp[k] + 1'b1;
        if (w_push_ch[k] && !w_pop[k])      r_cnt[k] <= r_cnt[k] + 1'b1;
        else if (!w_push_ch[k] && w_pop[k]) r_cnt[k] <= r_cnt[k] - 1'b1;
      end
    end
  end

  // Word storage; contents need no reset because empty channels mask their output
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_push_ch[k]) r_mem[k][r_wp[k]] <= in_data;
    end
  end

`ifdef DEMUX4WAY16_ROUTER_STATS_EN
  logic [7:0] r_stat_drops;

  // Saturating count of input stall cycles; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_drops <= 8'h00;
    end else if (stat_clr) begin
      r_stat_drops <= 8'h00;
    end else if (in_valid && !w_in_ready && r_stat_drops != 8'hFF) begin
      r_stat_drops <= r_stat_drops + 8'h01;
    end
  end

  assign stat_drops = r_stat_drops;
`endif

endmodule
